// File: rtl/vga_pkg.sv
// Shared definitions for the TinyVGA generator and receiver: lock states,
// Pmod pin indices and the 640x480@60 reference timing.
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    // Bit positions inside the 6-bit colour bus {R1,G1,B1,R0,G0,B0}
    localparam int PIN_B0 = 0;
    localparam int PIN_G0 = 1;
    localparam int PIN_R0 = 2;
    localparam int PIN_B1 = 3;
    localparam int PIN_G1 = 4;
    localparam int PIN_R1 = 5;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int H_SYNC   = 96;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int V_SYNC   = 2;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchronizer plus history flop for one sync pin; polarity is
// normalised before the synchronizer so that reset (all zero) means inactive.
module vga_sync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic active,
    output logic lead,
    output logic trail
);

    logic s1;
    logic s2;

    // active is the history flop; lead/trail are registered so all three align
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            active <= 1'b0;
            lead   <= 1'b0;
            trail  <= 1'b0;
        end else begin
            s1     <= pin ^ ACTIVE_LOW;
            s2     <= s1;
            active <= s2;
            lead   <= s2 & ~active;
            trail  <= ~s2 & active;
        end
    end

endmodule

// File: rtl/vga_timing_rx.sv
// TinyVGA receiver: recovers x/y position from the sync edges, measures line and
// frame timing and locks after two consecutive matching frames.
//   SEARCH  | waiting for a vsync leading edge to take references
//   MEASURE | one frame being compared against ref_h/ref_v
//   LOCKED  | timing stable, any deviation drops back to SEARCH
module vga_timing_rx
    import vga_pkg::*;
#(
    parameter int HCNT_W          = 11,
    parameter int VCNT_W          = 10,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [5:0]        rgb_in,
    output logic [HCNT_W-1:0] x_pos,
    output logic [VCNT_W-1:0] y_pos,
    output logic [5:0]        rgb_out,
    output logic              line_start,
    output logic              frame_start,
    output logic [HCNT_W-1:0] h_total,
    output logic [HCNT_W-1:0] h_sync_w,
    output logic [VCNT_W-1:0] v_total,
    output logic [VCNT_W-1:0] v_sync_w,
    output logic              locked,
    output logic              err
);

    localparam logic [HCNT_W-1:0] X_MAX = '1;
    localparam logic [VCNT_W-1:0] Y_MAX = '1;
    localparam logic [HCNT_W-1:0] X_ONE = HCNT_W'(1);
    localparam logic [VCNT_W-1:0] Y_ONE = VCNT_W'(1);

    logic h_act, h_lead, h_trail;
    logic v_act, v_lead, v_trail;

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (hsync_in),
        .active (h_act),
        .lead   (h_lead),
        .trail  (h_trail)
    );

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (vsync_in),
        .active (v_act),
        .lead   (v_lead),
        .trail  (v_trail)
    );

    logic [5:0]        rgb_s1, rgb_s2, rgb_h;
    logic              to_seen, h_seen, v_pend, line_bad;
    logic [HCNT_W-1:0] h_cnt, ref_h;
    logic [VCNT_W-1:0] v_cnt, ref_v;
    lock_state_t       state;

    logic              timeout;
    logic              h_valid;
    logic              h_bad;
    logic [HCNT_W-1:0] new_h;
    logic [HCNT_W-1:0] h_total_nx;
    logic [VCNT_W-1:0] new_v;

    assign timeout    = (x_pos == X_MAX) && !to_seen;
    assign new_h      = x_pos + X_ONE;
    assign new_v      = y_pos + Y_ONE;
    assign h_valid    = h_lead && h_seen && !timeout;
    assign h_total_nx = h_valid ? new_h : h_total;
    // Compare against the value being latched this cycle so a coincident v edge sees it
    assign h_bad      = h_valid && (new_h != ref_h);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_s1      <= '0;
            rgb_s2      <= '0;
            rgb_h       <= '0;
            rgb_out     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            v_pend      <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            to_seen     <= 1'b0;
            h_seen      <= 1'b0;
            h_total     <= '0;
            h_cnt       <= '0;
            h_sync_w    <= '0;
            v_total     <= '0;
            v_cnt       <= '0;
            v_sync_w    <= '0;
        end else begin
            rgb_s1      <= rgb_in;
            rgb_s2      <= rgb_s1;
            rgb_h       <= rgb_s2;
            rgb_out     <= rgb_h;
            line_start  <= h_lead;
            frame_start <= h_lead && (v_pend || v_lead);

            if (h_lead)
                v_pend <= 1'b0;
            else if (v_lead)
                v_pend <= 1'b1;

            if (h_lead)
                x_pos <= '0;
            else if (x_pos != X_MAX)
                x_pos <= new_h;

            to_seen <= h_lead ? 1'b0 : (to_seen | timeout);
            h_seen  <= timeout ? 1'b0 : (h_seen | h_lead);

            if (h_valid)
                h_total <= new_h;

            if (h_lead)
                h_cnt <= X_ONE;
            else if (h_act && (h_cnt != X_MAX))
                h_cnt <= h_cnt + X_ONE;

            if (h_trail)
                h_sync_w <= h_cnt;

            // v edge wins over a coincident h edge
            if (v_lead)
                y_pos <= '0;
            else if (h_lead && (y_pos != Y_MAX))
                y_pos <= new_v;

            if (v_lead)
                v_total <= new_v;

            if (v_lead)
                v_cnt <= h_lead ? Y_ONE : '0;
            else if (v_act && h_lead && (v_cnt != Y_MAX))
                v_cnt <= v_cnt + Y_ONE;

            if (v_trail)
                v_sync_w <= v_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            ref_h    <= '0;
            ref_v    <= '0;
            line_bad <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (timeout) begin
                state  <= SEARCH;
                locked <= 1'b0;
                err    <= 1'b1;
            end else begin
                case (state)
                    SEARCH: begin
                        locked <= 1'b0;
                        if (v_lead) begin
                            state    <= MEASURE;
                            ref_v    <= new_v;
                            ref_h    <= h_total_nx;
                            line_bad <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (v_lead) begin
                            if ((new_v == ref_v) && !(line_bad || h_bad)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                ref_v    <= new_v;
                                ref_h    <= h_total_nx;
                                line_bad <= 1'b0;
                            end
                        end else if (h_bad) begin
                            line_bad <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (h_bad || (v_lead && (new_v != ref_v))) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
